// File: rtl/spi_master_ctrl.sv
// Single-transaction SPI master (mode 0, MSB first) driving a shared chip-select plus a 2-bit slave code.
// Optional build macro SPI_LOOPBACK_EN adds a LOOPBACK input that feeds MOSI back into the receive sampler.
module spi_master_ctrl #(
    parameter int MAX_BITS = 32,
    parameter int CLK_DIV  = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [1:0]          SLAVE_IN,
    input  logic [5:0]          NUM_BITS,
    input  logic [MAX_BITS-1:0] TX_DATA,
`ifdef SPI_LOOPBACK_EN
    input  logic                LOOPBACK,
`endif
    output logic                BUSY,
    output logic                DONE,
    output logic [MAX_BITS-1:0] RX_DATA,
    output logic                SPI_SCLK,
    output logic                SPI_MOSI,
    input  logic                SPI_MISO,
    output logic                SPI_CS,
    output logic [1:0]          SLAVE_SELECT
);

    localparam int              DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [6:0]      MAX_BITS_W = 7'(MAX_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } state_t;

    // Handshake: START is sampled only in IDLE; BUSY rises on the accepting edge and
    // falls on the edge that raises the one-cycle DONE pulse; START while BUSY is dropped.
    state_t              state, state_nxt;
    logic [DW-1:0]       div_cnt, div_nxt;
    logic [5:0]          bit_cnt, bit_nxt;
    logic [MAX_BITS-1:0] tx_shift, tx_nxt;
    logic [MAX_BITS-1:0] rx_shift, rx_nxt;
    logic [MAX_BITS-1:0] rx_q, rx_q_nxt;
    logic                sclk_q, sclk_nxt;
    logic                mosi_q, mosi_nxt;
    logic                cs_q, cs_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic [1:0]          ss_q, ss_nxt;
    logic [5:0]          num_clamped;
    logic [6:0]          shamt;
    logic                div_end;
    logic                rx_bit;

    assign num_clamped = ({1'b0, NUM_BITS} > MAX_BITS_W) ? MAX_BITS_W[5:0] : NUM_BITS;
    // TX is MSB-aligned at accept so the serialiser always reads the top bit.
    assign shamt       = MAX_BITS_W - {1'b0, num_clamped};
    assign div_end     = (div_cnt == DIV_LAST);

`ifdef SPI_LOOPBACK_EN
    logic lb_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lb_q <= 1'b0;
        end else if (state == IDLE && START) begin
            lb_q <= LOOPBACK;
        end
    end

    assign rx_bit = lb_q ? mosi_q : SPI_MISO;
`else
    assign rx_bit = SPI_MISO;
`endif

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        tx_nxt    = tx_shift;
        rx_nxt    = rx_shift;
        rx_q_nxt  = rx_q;
        sclk_nxt  = sclk_q;
        mosi_nxt  = mosi_q;
        cs_nxt    = cs_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        ss_nxt    = ss_q;

        case (state)
            IDLE: begin
                div_nxt = '0;
                if (START) begin
                    ss_nxt    = SLAVE_IN;
                    busy_nxt  = 1'b1;
                    bit_nxt   = num_clamped;
                    tx_nxt    = TX_DATA << shamt;
                    rx_nxt    = '0;
                    state_nxt = SEL;
                end
            end
            SEL: begin
                // SLAVE_SELECT has been stable for a full cycle before CS can fall here.
                div_nxt = '0;
                if (bit_cnt == 6'd0) begin
                    state_nxt = GAP;
                end else begin
                    cs_nxt    = 1'b0;
                    mosi_nxt  = tx_shift[MAX_BITS-1];
                    tx_nxt    = tx_shift << 1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_nxt   = '0;
                    sclk_nxt  = 1'b1;
                    rx_nxt    = rx_shift << 1;
                    rx_nxt[0] = rx_bit;
                    state_nxt = SHIFT_HI;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    div_nxt   = '0;
                    sclk_nxt  = 1'b0;
                    mosi_nxt  = tx_shift[MAX_BITS-1];
                    tx_nxt    = tx_shift << 1;
                    state_nxt = SHIFT_LO;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_nxt = '0;
                    bit_nxt = bit_cnt - 6'd1;
                    if (bit_cnt == 6'd1) begin
                        cs_nxt    = 1'b1;
                        mosi_nxt  = 1'b0;
                        rx_q_nxt  = rx_shift;
                        state_nxt = GAP;
                    end else begin
                        sclk_nxt  = 1'b1;
                        rx_nxt    = rx_shift << 1;
                        rx_nxt[0] = rx_bit;
                        state_nxt = SHIFT_HI;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (div_end) begin
                    div_nxt   = '0;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ss_q     <= 2'd0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            bit_cnt  <= bit_nxt;
            tx_shift <= tx_nxt;
            rx_shift <= rx_nxt;
            rx_q     <= rx_q_nxt;
            sclk_q   <= sclk_nxt;
            mosi_q   <= mosi_nxt;
            cs_q     <= cs_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            ss_q     <= ss_nxt;
        end
    end

    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign RX_DATA      = rx_q;
    assign SPI_SCLK     = sclk_q;
    assign SPI_MOSI     = mosi_q;
    assign SPI_CS       = cs_q;
    assign SLAVE_SELECT = ss_q;

endmodule
